instr_encoder: RTL

//  Packs decoded fields (format, regs, funct3, 64-bit signed immediate) into 32-bit RV64 instruction words.

---
 rtl/instr_encoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// ============================================================================
// Module  : instr_encoder
// Purpose : Packs decoded RV64 fields into 32-bit instruction words and streams
//           them with byte addresses through a one-deep valid/ready stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_INSTR = 256,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [63:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err,
    output logic [ERR_W-1:0]  err_count
);

    localparam int                CNT_W  = $clog2(MAX_INSTR + 1);
    localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(MAX_INSTR - 1);
    localparam logic [ADDR_W-1:0] c_BASE = ADDR_W'(BASE_ADDR);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_next_addr;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_count;

    logic        w_in_ready;
    logic        w_done;
    logic        w_accept;
    logic        w_legal;
    logic        w_legal_acc;
    logic        w_start_run;
    logic [11:0] w_i;
    logic [31:0] w_instr;

    // Representable iff bits 63..11 are a pure sign extension (-2048..2047).
    assign w_legal     = (&imm[63:11]) | ~(|imm[63:11]);
    assign w_accept    = in_valid & w_in_ready;
    assign w_legal_acc = w_accept & w_legal;
    assign w_start_run = start & ~r_out_valid & (r_state != S_RUN);
    assign w_i         = imm[11:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_run) w_state_nxt = S_RUN;
            S_RUN:   if (w_legal_acc && (r_count == c_LAST)) w_state_nxt = S_DONE;
            S_DONE:  if (w_start_run) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_RUN:   w_in_ready = ~r_out_valid | out_ready;
            S_DONE:  w_done     = 1'b1;
            default: ;
        endcase
    end

    // Branch immediates arrive in halfword units, so i[k] is byte-offset bit k+1.
    always_comb begin
        w_instr = 32'd0;
        case (fmt)
            2'd0:    w_instr = {w_i, rs1, funct3, rd, 7'b0010011};
            2'd1:    w_instr = {w_i, rs1, funct3, rd, 7'b0000011};
            2'd2:    w_instr = {w_i[11:5], rs2, rs1, funct3, w_i[4:0], 7'b0100011};
            default: w_instr = {w_i[11], w_i[9:4], rs2, rs1, funct3, w_i[3:0], w_i[10], 7'b1100011};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_addr  <= c_BASE;
            r_next_addr <= c_BASE;
            r_count     <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            if (w_legal_acc) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_instr;
                r_out_addr  <= r_next_addr;
                r_next_addr <= r_next_addr + ADDR_W'(4);
                r_count     <= r_count + CNT_W'(1);
            end else if (w_accept) begin
                r_err <= 1'b1;
                if (r_err_count != {ERR_W{1'b1}}) begin
                    r_err_count <= r_err_count + ERR_W'(1);
                end
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_start_run) begin
                r_next_addr <= c_BASE;
                r_count     <= '0;
                r_err       <= 1'b0;
                r_err_count <= '0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign done      = w_done;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

`default_nettype wire
